fifo_serializer: RTL and testbench

- Downstream consumer of the 4-bit synchronous FIFO: pops one word at a time through the FIFO read port (r_en / dread / empty_indicate).
- Transmits each word LSB-first as an asynchronous serial frame: 1 start bit (0), WIDTH data bits, 1 stop bit (1).
- Handles the FIFO's registered read: dread is valid on the cycle after r_en is sampled.
- Sits between the FIFO and the off-chip serial line.

---
 rtl/fifo_ser_pkg.sv | 23 ++
 rtl/fifo_serializer_if.sv | 27 ++
 rtl/ser_bit_timer.sv | 33 +++
 rtl/fifo_serializer.sv | 138 +++++++++++++
 tb/tb_fifo_serializer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ser_pkg.sv
// fifo_serializer shared definitions: FSM state encoding, serial line levels
// and a helper that sizes the bit timer counter.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } ser_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  // Bit timer width: $clog2 of the bit period, never narrower than one bit.
  function automatic int timer_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// fifo_serializer bus: FIFO read port, transmit enable and the serial side.
// master = the serializer, slave = the FIFO/line environment around it.
interface fifo_serializer_if
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             tx_en;
  logic             empty_indicate;
  logic [WIDTH-1:0] dread;
  logic             r_en;
  logic             ser_out;
  logic             busy;
  logic             frame_done;

  modport master (
    input  tx_en, empty_indicate, dread,
    output r_en, ser_out, busy, frame_done
  );

  modport slave (
    output tx_en, empty_indicate, dread,
    input  r_en, ser_out, busy, frame_done
  );

endinterface

// File: rtl/ser_bit_timer.sv
// ser_bit_timer: free-running bit period counter with synchronous clear.
// bit_end is high on the last clock of each CLKS_PER_BIT-cycle bit.
module ser_bit_timer
  import fifo_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
)
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = timer_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Count 0..CLKS_PER_BIT-1 and wrap, held at zero while cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from a synchronous FIFO and sends each one
// LSB-first as start bit, WIDTH data bits, optional parity, stop bit.
// Define FIFO_SER_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_serializer
  import fifo_ser_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
)
(
  input logic               clk,
  input logic               reset,
  fifo_serializer_if.master bus
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);

  ser_state_e       state_q;
  ser_state_e       state_d;
  logic [WIDTH-1:0] shift_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic             bit_end;
  logic             timer_clear;
  logic             line;
  logic             pop;
  logic             done;
`ifdef FIFO_SER_PARITY_EN
  logic             parity_q;
`endif

  // The timer only runs while a bit is on the line.
  assign timer_clear = (state_q == IDLE) || (state_q == REQ) || (state_q == LOAD);

  ser_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and output decode, purely from registered state.
  always_comb begin
    state_d = state_q;
    line    = LINE_IDLE;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_en && !bus.empty_indicate) begin
          state_d = REQ;
        end
      end
      REQ: begin
        pop     = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        line = START_BIT;
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        line = shift_q[0];
        if (bit_end && (bit_idx_q == LAST_BIT)) begin
`ifdef FIFO_SER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FIFO_SER_PARITY_EN
      PARITY: begin
        line = parity_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        done = bit_end;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the word the cycle after the pop, then shift one bit per period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else if (state_q == LOAD) begin
      shift_q   <= bus.dread;
      bit_idx_q <= '0;
    end else if ((state_q == DATA) && bit_end) begin
      shift_q   <= shift_q >> 1;
      bit_idx_q <= bit_idx_q + 1'b1;
    end
  end

`ifdef FIFO_SER_PARITY_EN
  // Parity comes from the captured word, independent of the shifting copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (state_q == LOAD) begin
      parity_q <= ^bus.dread;
    end
  end
`endif

  assign bus.r_en       = pop;
  assign bus.ser_out    = line;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = done;

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer with a registered-read FIFO model and a frame
// scoreboard. Honours FIFO_SER_PARITY_EN for the frame layout.
module tb_fifo_serializer;

  localparam int WIDTH = 4;
  localparam int CPB   = 4;
`ifdef FIFO_SER_PARITY_EN
  localparam int FL = (WIDTH + 3) * CPB;
`else
  localparam int FL = (WIDTH + 2) * CPB;
`endif

  logic clk = 1'b0;
  logic reset;

  fifo_serializer_if #(.WIDTH(WIDTH)) bus ();

  fifo_serializer #(
    .WIDTH       (WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ren_count = 0;
  int last_ren_cycle = 0;
  int frames_started = 0;
  int frames_seen = 0;
  int start_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] word);
    fifo_q.push_back(word);
  endtask

  task automatic waitFrames(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames_seen >= target) break;
    end
    checkOutput("frames_seen", frames_seen, target);
  endtask

  task automatic waitStart(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (frames_started >= target) break;
      @(negedge clk);
    end
    checkOutput("frame_started", frames_started, target);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.r_en) begin
        ren_count++;
        last_ren_cycle = cycle;
      end
    end
  end

  // FIFO model: a pop requested in one cycle shows on dread after the next edge.
  initial begin : fifo_model
    bit pop_pending;
    bus.dread = '0;
    bus.empty_indicate = 1'b1;
    forever begin
      @(negedge clk);
      pop_pending = bus.r_en && !reset;
      @(posedge clk);
      #1;
      if (reset) begin
        fifo_q.delete();
      end else if (pop_pending && (fifo_q.size() > 0)) begin
        bus.dread = fifo_q.pop_front();
        exp_q.push_back(bus.dread);
      end
      bus.empty_indicate = (fifo_q.size() == 0);
    end
  end

  // Line monitor: decode each frame at mid-bit and compare with the scoreboard.
  initial begin : monitor
    logic [WIDTH+2:0] samples;
    logic [WIDTH-1:0] w;
    int done_cnt;
    int done_at;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset || bus.ser_out) continue;
      start_q.push_back(cycle);
      frames_started++;
      samples  = '1;
      done_cnt = 0;
      done_at  = -1;
      aborted  = 0;
      for (int c = 0; c < FL; c++) begin
        if (c > 0) @(negedge clk);
        if (reset) begin
          aborted = 1;
          break;
        end
        if ((c % CPB) == (CPB / 2)) samples[c / CPB] = bus.ser_out;
        if (bus.frame_done) begin
          done_cnt++;
          done_at = c;
        end
      end
      if (aborted) begin
        if (exp_q.size() > 0) w = exp_q.pop_front();
        continue;
      end
      checkOutput("sb_has_entry", 32'(exp_q.size() > 0), 1);
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checkOutput("start_bit", samples[0], 0);
      checkOutput("data_bits", samples[WIDTH:1], w);
`ifdef FIFO_SER_PARITY_EN
      checkOutput("parity_bit", samples[WIDTH+1], ^w);
`endif
      checkOutput("stop_bit", samples[FL/CPB-1], 1);
      checkOutput("frame_done_count", done_cnt, 1);
      checkOutput("frame_done_pos", done_at, FL - 1);
      frames_seen++;
    end
  end

  initial begin : main
    int base;
    int f0;
    int s0;
    int bad_line;
    int bad_busy;

    reset = 1'b1;
    bus.tx_en = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ser_out", bus.ser_out, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_r_en", bus.r_en, 0);
    checkOutput("reset_frame_done", bus.frame_done, 0);
    reset = 1'b0;

    // Empty FIFO with transmit enabled must leave the line alone.
    bus.tx_en = 1'b1;
    base = ren_count;
    bad_line = 0;
    bad_busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.ser_out) bad_line++;
      if (bus.busy) bad_busy++;
    end
    checkOutput("empty_r_en", ren_count - base, 0);
    checkOutput("empty_line_low", bad_line, 0);
    checkOutput("empty_busy", bad_busy, 0);

    // Single word.
    base = ren_count;
    f0 = frames_seen;
    applyStimulus(4'b1001);
    waitFrames(f0 + 1, 100);
    checkOutput("single_r_en", ren_count - base, 1);
    checkOutput("single_latency", start_q[$] - last_ren_cycle, 2);
    @(negedge clk);
    checkOutput("single_idle_busy", bus.busy, 0);

    // Back-to-back words.
    base = ren_count;
    f0 = frames_seen;
    s0 = start_q.size();
    applyStimulus(4'b1001);
    applyStimulus(4'b1011);
    applyStimulus(4'b0011);
    waitFrames(f0 + 3, 300);
    checkOutput("b2b_r_en", ren_count - base, 3);
    for (int i = 0; i < 2; i++) begin
      checkOutput("b2b_gap", start_q[s0+i+1] - start_q[s0+i] - FL, 3);
    end

    // tx_en dropped mid-frame: frame completes, no further fetch.
    base = ren_count;
    f0 = frames_seen;
    s0 = frames_started;
    applyStimulus(4'b1001);
    applyStimulus(4'b0110);
    waitStart(s0 + 1, 50);
    repeat (8) @(negedge clk);
    bus.tx_en = 1'b0;
    waitFrames(f0 + 1, 100);
    repeat (20) @(negedge clk);
    checkOutput("txdrop_r_en", ren_count - base, 1);
    checkOutput("txdrop_busy", bus.busy, 0);
    bus.tx_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("txdrop_refetch", bus.r_en, 1);
    waitFrames(f0 + 2, 100);

    // Reset during data bit 2 of 1011 (bit value 0).
    s0 = frames_started;
    applyStimulus(4'b1011);
    waitStart(s0 + 1, 50);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_line", bus.ser_out, 0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_ser_out", bus.ser_out, 1);
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_r_en", bus.r_en, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    f0 = frames_seen;
    applyStimulus(4'b0101);
    waitFrames(f0 + 1, 100);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
